// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit.
// Owns the architectural HI/LO registers and runs mult/multu/div/divu with a
// fixed multi-cycle latency. It also services mthi/mtlo moves while idle.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low; clears all state
//   start  one-cycle request, qualifies op 1..4
//   op     0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//   A, B   rs / rt operands (forwarded values)
//   busy   operation in flight
//   HI, LO architectural HI / LO (registered)
module e_mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } op_e;

    op_e         opc;
    logic [31:0] pend_hi, pend_lo;
    logic [3:0]  cnt;

    // combinational result of the requested operation
    logic [31:0] res_hi, res_lo;
    logic        launch;
    logic [3:0]  launch_cnt;
    logic [63:0] prod;
    logic [31:0] mag_a, mag_b, div_b, uq, ur;
    logic        is_signed;

    assign opc  = op_e'(op);
    assign busy = (cnt != 4'd0);

    always_comb begin
        launch     = 1'b0;
        launch_cnt = '0;
        res_hi     = '0;
        res_lo     = '0;
        prod       = '0;
        is_signed  = (opc == OP_DIV);
        // signed division works on magnitudes; signs are restored afterwards
        mag_a      = (is_signed && A[31]) ? (~A + 32'd1) : A;
        mag_b      = (is_signed && B[31]) ? (~B + 32'd1) : B;
        div_b      = (mag_b == 32'd0) ? 32'd1 : mag_b;
        uq         = mag_a / div_b;
        ur         = mag_a % div_b;
        case (opc)
            OP_MULT: begin
                // low 64 bits of a product of sign-extended operands are the signed product
                prod       = {{32{A[31]}}, A} * {{32{B[31]}}, B};
                res_hi     = prod[63:32];
                res_lo     = prod[31:0];
                launch     = start;
                launch_cnt = 4'(MULT_CYCLES);
            end
            OP_MULTU: begin
                prod       = {32'd0, A} * {32'd0, B};
                res_hi     = prod[63:32];
                res_lo     = prod[31:0];
                launch     = start;
                launch_cnt = 4'(MULT_CYCLES);
            end
            OP_DIV, OP_DIVU: begin
                if (B == 32'd0) begin
                    res_lo = '1;
                    res_hi = A;
                end else begin
                    // 0x80000000 / -1 falls out naturally: magnitude 2^31, positive sign
                    res_lo = (is_signed && (A[31] ^ B[31])) ? (~uq + 32'd1) : uq;
                    res_hi = (is_signed && A[31]) ? (~ur + 32'd1) : ur;
                end
                launch     = start;
                launch_cnt = 4'(DIV_CYCLES);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            HI      <= '0;
            LO      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            cnt     <= '0;
        end else if (cnt > 4'd1) begin
            cnt <= cnt - 4'd1;
        end else begin
            if (cnt == 4'd1) begin
                // final busy edge: retire the result; a new start may be accepted in the same edge
                HI <= pend_hi;
                LO <= pend_lo;
            end else if (opc == OP_MTHI) begin
                HI <= A;
            end else if (opc == OP_MTLO) begin
                LO <= A;
            end
            if (launch) begin
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                cnt     <= launch_cnt;
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: doc/e_mdu.md
# e_mdu

Execute-stage multiply/divide unit of the five-stage MIPS pipeline: owns the architectural HI and LO registers, executes mult/multu/div/divu with fixed multi-cycle latency, and services mthi/mtlo writes. Its HI/LO outputs travel down the E→M→W pipeline registers for mfhi/mflo writeback. The hazard unit stalls D-stage on `start | busy` whenever an MDU instruction follows.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu
- DIV_CYCLES, 10, busy cycles for div/divu
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low; clears all state
- start  input  1  one-cycle request, qualifies op 1–4
- op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- A  input  32  rs operand (forwarded value)
- B  input  32  rt operand (forwarded value)
- busy  output  1  operation in flight
- HI  output  32  architectural HI
- LO  output  32  architectural LO

## Operation
- State: HI, LO, pendHI, pendLO (32 each), down-counter cnt (4 bits, enough for DIV_CYCLES ≤ 15). busy = (cnt != 0).
- Reset (reset=0, asynchronous): HI=LO=pendHI=pendLO=0, cnt=0, busy=0. Any in-flight operation is discarded.
- Idle accept: at a rising edge with busy=0, start=1 and op∈{1..4}:
  - pendHI/pendLO ← result computed from A,B sampled at that edge.
  - cnt ← MULT_CYCLES (op 1,2) or DIV_CYCLES (op 3,4).
- Countdown: each edge with cnt>0 decrements cnt. On the edge where cnt goes 1→0, HI←pendHI and LO←pendLO.
- mthi/mtlo: op=5 at an edge with busy=0 writes HI←A. op=6 writes LO←A. start is not required.
- While busy=1, all start and op values are ignored, including mthi/mtlo, and HI/LO hold. The hazard unit guarantees no such request; the ignore behaviour is still mandatory.
- start=1 with op∈{0,5,6,7} does not launch an operation. op 5/6 still perform their move.
- Arithmetic:
  - mult: signed 32×32→64; HI=product[63:32], LO=product[31:0]. multu is the unsigned version.
  - div: signed; LO=quotient truncated toward zero; HI=remainder, which takes the dividend's sign. divu is the unsigned version.
  - Divide by zero (div and divu): LO=0xFFFFFFFF, HI=A.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.

## Timing
- Accept edge t0: busy=1 from just after t0 through edge t0+N, where N is the configured cycle count, so busy is high for exactly N cycles.
- HI/LO change at edge t0+N. busy falls at that same edge.
- The next operation can be accepted at edge t0+N. A start held high through the busy window is therefore accepted at t0+N with the then-current A/B.
- mthi/mtlo take effect at the sampling edge; the new value is visible the next cycle.
- HI/LO are register outputs with no combinational path from inputs.
- Reset asserted mid-operation forces busy=0 and HI=LO=0 immediately, with no clock needed. After reset deasserts, the first edge may accept a new start.

## Test plan
- mult A=0xFFFFFFFD(−3), B=5 → busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1. HI/LO unchanged during busy.
- multu A=B=0xFFFFFFFF → after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- div A=0xFFFFFFF9(−7), B=2 → busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Boundaries:
  - divu A=7, B=0 → LO=0xFFFFFFFF, HI=7.
  - div A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- mthi A=0x12345678 while idle → HI=0x12345678 next cycle. During a mult busy window:
  - mtlo A=0xAAAA and a second start (divu) → both ignored.
  - Final LO is the mult result. busy stays high exactly 5 cycles total.
- Start mult 3×4, then drive reset=0 asynchronously 2 cycles later (mid-cycle) → busy=0, HI=LO=0 immediately. After release, the pending result never appears. A fresh multu 3×4 gives LO=12 after 5 cycles.
